// File: rtl/vga_timing_pkg.sv
// Shared XGA (1024x768 @ 60 Hz) timing constants for the timing generator and draw stages.
// Totals are derived here so every consumer agrees on the frame geometry.
package vga_timing_pkg;

  localparam int CNT_W = 11;

  localparam int XGA_H_VISIBLE = 1024;
  localparam int XGA_H_FRONT   = 24;
  localparam int XGA_H_SYNC    = 136;
  localparam int XGA_H_BACK    = 160;
  localparam int XGA_V_VISIBLE = 768;
  localparam int XGA_V_FRONT   = 3;
  localparam int XGA_V_SYNC    = 6;
  localparam int XGA_V_BACK    = 29;

  localparam int XGA_H_TOTAL = XGA_H_VISIBLE + XGA_H_FRONT + XGA_H_SYNC + XGA_H_BACK;
  localparam int XGA_V_TOTAL = XGA_V_VISIBLE + XGA_V_FRONT + XGA_V_SYNC + XGA_V_BACK;

endpackage

// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel/line counters with sync, blanking and frame-start flags.
// All outputs are registered and derived from the next-count values, so they describe the same pixel.
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = XGA_H_VISIBLE,
  parameter int H_FRONT   = XGA_H_FRONT,
  parameter int H_SYNC    = XGA_H_SYNC,
  parameter int H_BACK    = XGA_H_BACK,
  parameter int V_VISIBLE = XGA_V_VISIBLE,
  parameter int V_FRONT   = XGA_V_FRONT,
  parameter int V_SYNC    = XGA_V_SYNC,
  parameter int V_BACK    = XGA_V_BACK
) (
  input  logic             pclk,
  input  logic             rst,
  output logic [CNT_W-1:0] hcount_out,
  output logic [CNT_W-1:0] vcount_out,
  output logic             hsync_out,
  output logic             hblnk_out,
  output logic             vsync_out,
  output logic             vblnk_out,
  output logic             frame_start
);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_BEGIN = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_BEGIN = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] v_nxt;
  logic             hsync_nxt;
  logic             hblnk_nxt;
  logic             vsync_nxt;
  logic             vblnk_nxt;
  logic             frame_start_nxt;

  always_comb begin
    h_nxt           = hcount_out + CNT_W'(1);
    v_nxt           = vcount_out;
    frame_start_nxt = 1'b0;
    if (hcount_out == H_LAST) begin
      h_nxt = '0;
      if (vcount_out == V_LAST) begin
        v_nxt           = '0;
        frame_start_nxt = 1'b1;
      end else begin
        v_nxt = vcount_out + CNT_W'(1);
      end
    end
    // Flags follow the next counts so they land in the same cycle as the counts they describe.
    hblnk_nxt = (h_nxt >= H_VIS);
    hsync_nxt = (h_nxt >= HS_BEGIN) && (h_nxt <= HS_END);
    vblnk_nxt = (v_nxt >= V_VIS);
    vsync_nxt = (v_nxt >= VS_BEGIN) && (v_nxt <= VS_END);
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hcount_out  <= '0;
      vcount_out  <= '0;
      hsync_out   <= 1'b0;
      hblnk_out   <= 1'b0;
      vsync_out   <= 1'b0;
      vblnk_out   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hcount_out  <= h_nxt;
      vcount_out  <= v_nxt;
      hsync_out   <= hsync_nxt;
      hblnk_out   <= hblnk_nxt;
      vsync_out   <= vsync_nxt;
      vblnk_out   <= vblnk_nxt;
      frame_start <= frame_start_nxt;
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench: an XGA instance for reset and line-level timing, plus a shrunken-geometry
// instance (58x40 frame) so whole-frame and mid-frame-reset behaviour fits in a short run.
module tb_vga_timing;

  logic        pclk = 1'b0;
  logic        rst_x = 1'b1;
  logic        rst_s = 1'b1;

  logic [10:0] xh, xv, sh, sv;
  logic        xhs, xhb, xvs, xvb, xfs;
  logic        shs, shb, svs, svb, sfs;

  int vectors = 0;
  int miscompares = 0;

  always #5 pclk = ~pclk;

  vga_timing u_xga (
    .pclk(pclk), .rst(rst_x),
    .hcount_out(xh), .vcount_out(xv),
    .hsync_out(xhs), .hblnk_out(xhb), .vsync_out(xvs), .vblnk_out(xvb),
    .frame_start(xfs)
  );

  // H: 40/4/6/8 -> total 58, hsync 44..49. V: 30/2/3/5 -> total 40, vsync lines 32..34.
  vga_timing #(
    .H_VISIBLE(40), .H_FRONT(4), .H_SYNC(6), .H_BACK(8),
    .V_VISIBLE(30), .V_FRONT(2), .V_SYNC(3), .V_BACK(5)
  ) u_small (
    .pclk(pclk), .rst(rst_s),
    .hcount_out(sh), .vcount_out(sv),
    .hsync_out(shs), .hblnk_out(shb), .vsync_out(svs), .vblnk_out(svb),
    .frame_start(sfs)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_x(input int h, input int v, input string tag);
    int n = 0;
    while (!(xh == 11'(h) && xv == 11'(v)) && n < 20000) begin
      @(negedge pclk);
      n++;
    end
    if (n >= 20000) chk(tag, 0, 1);
  endtask

  task automatic wait_s(input int h, input int v, input string tag);
    int n = 0;
    while (!(sh == 11'(h) && sv == 11'(v)) && n < 5000) begin
      @(negedge pclk);
      n++;
    end
    if (n >= 5000) chk(tag, 0, 1);
  endtask

  int hs_n, hs_first, hb_n, hb_first, skew_bad;
  int fr_n, vs_n, vb_n;

  initial begin
    // Reset held for 5 cycles: everything forced low.
    repeat (5) @(negedge pclk);
    chk("rst_hcount", xh, 0);
    chk("rst_vcount", xv, 0);
    chk("rst_flags", {xhs, xhb, xvs, xvb, xfs}, 0);
    chk("rst_small_flags", {shs, shb, svs, svb, sfs}, 0);
    rst_x = 1'b0;
    rst_s = 1'b0;
    @(negedge pclk);
    chk("rel_hcount", xh, 1);
    chk("rel_vcount", xv, 0);
    chk("rel_frame_start", xfs, 0);

    // Sweep one full XGA line starting at h=1.
    hs_n = 0; hs_first = -1; hb_n = 0; hb_first = -1; skew_bad = 0;
    for (int i = 0; i < 1344; i++) begin
      if (xhs) begin hs_n++; if (hs_first < 0) hs_first = xh; end
      if (xhb) begin hb_n++; if (hb_first < 0) hb_first = xh; end
      if (xhs != (xh >= 1048 && xh <= 1183)) skew_bad++;
      if (xhb != (xh >= 1024)) skew_bad++;
      @(negedge pclk);
    end
    chk("hsync_width", hs_n, 136);
    chk("hsync_start", hs_first, 1048);
    chk("hblnk_width", hb_n, 320);
    chk("hblnk_start", hb_first, 1024);
    chk("hflag_align", skew_bad, 0);
    chk("line1_vblnk", xvb, 0);

    // Line wrap bumps the line counter.
    wait_x(1343, 10, "wait_x_1343_10");
    chk("pre_wrap_hcount", xh, 1343);
    @(negedge pclk);
    chk("wrap_hcount", xh, 0);
    chk("wrap_vcount", xv, 11);
    chk("wrap_frame_start", xfs, 0);

    // Frame wrap on the small instance.
    wait_s(57, 39, "wait_s_57_39");
    chk("pre_frame_vblnk", svb, 1);
    chk("pre_frame_fs", sfs, 0);
    @(negedge pclk);
    chk("frame_hcount", sh, 0);
    chk("frame_vcount", sv, 0);
    chk("frame_start_pulse", sfs, 1);
    chk("frame_flags", {shs, shb, svs, svb}, 0);

    // Sweep the whole frame until the next frame_start.
    fr_n = 0; vs_n = 0; vb_n = 0;
    while (fr_n < 5000) begin
      if (svs) vs_n++;
      if (svb) vb_n++;
      @(negedge pclk);
      fr_n++;
      if (fr_n == 1) chk("frame_start_width", sfs, 0);
      if (sfs) break;
    end
    chk("frame_period", fr_n, 2320);
    chk("vsync_cycles", vs_n, 174);
    chk("vblnk_cycles", vb_n, 580);

    // Asynchronous reset mid-frame with every flag active.
    wait_s(45, 33, "wait_s_45_33");
    chk("pre_rst_flags", {shs, shb, svs, svb}, 4'b1111);
    #2 rst_s = 1'b1;
    #1;
    chk("async_rst_hcount", sh, 0);
    chk("async_rst_vcount", sv, 0);
    chk("async_rst_flags", {shs, shb, svs, svb, sfs}, 0);
    repeat (2) @(negedge pclk);
    rst_s = 1'b0;
    @(negedge pclk);
    chk("restart_hcount", sh, 1);
    chk("restart_vcount", sv, 0);
    chk("restart_frame_start", sfs, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
